// File: rtl/stk_pipe_mem_mbank.sv
// stk_pipe_mem_mbank: CH_N request channels sharing BANKS_N single-port SRAM banks,
// per-bank round-robin grant, reads returned tagged after a fixed RD_LAT cycles.
module stk_pipe_mem_mbank #(
    parameter int CH_N    = 2,
    parameter int BANKS_N = 4,
    parameter int LINES_N = 256,
    parameter int DATA_W  = 128,
    parameter int TAG_W   = 4,
    parameter int RD_LAT  = 2,
    localparam int BANK_W = (BANKS_N > 1) ? $clog2(BANKS_N) : 1,
    localparam int ADDR_W = $clog2(LINES_N)
) (
    input  logic                   clk_i,
    input  logic                   arst_i,
    input  logic [CH_N-1:0]        req_vld_i,
    output logic [CH_N-1:0]        req_rdy_o,
    input  logic [CH_N-1:0]        req_wr_i,
    input  logic [CH_N*BANK_W-1:0] req_bank_i,
    input  logic [CH_N*ADDR_W-1:0] req_addr_i,
    input  logic [CH_N*DATA_W-1:0] req_wdata_i,
    input  logic [CH_N*TAG_W-1:0]  req_tag_i,
    output logic [CH_N-1:0]        rsp_vld_o,
    output logic [CH_N*TAG_W-1:0]  rsp_tag_o,
    output logic [CH_N*DATA_W-1:0] rsp_dat_o,
    output logic [15:0]            cflt_cnt_o
);
    localparam int PTR_W = (CH_N > 1) ? $clog2(CH_N) : 1;

    logic [BANKS_N-1:0][PTR_W-1:0]           rr_q, rr_d;
    logic [15:0]                             cflt_q, cflt_d;
    logic [RD_LAT-1:0][CH_N-1:0]             p_vld_q, p_vld_d;
    logic [RD_LAT-1:0][CH_N-1:0][TAG_W-1:0]  p_tag_q, p_tag_d;
    logic [RD_LAT-1:0][CH_N-1:0][DATA_W-1:0] p_dat_q, p_dat_d;
    logic [DATA_W-1:0]                       mem_q [BANKS_N][LINES_N];
    logic [BANKS_N-1:0]                      bk_hit, bk_we;
    logic [BANKS_N-1:0][ADDR_W-1:0]          bk_addr;
    logic [BANKS_N-1:0][DATA_W-1:0]          bk_wdat;
    logic [CH_N-1:0]                         gnt, rd_acc, bad_bank;
    int                                      idx;

    // Scan channels starting at each bank's pointer; first hit wins and owns the bank port.
    always_comb begin
        gnt     = '0;
        rr_d    = rr_q;
        bk_hit  = '0;
        bk_we   = '0;
        bk_addr = '0;
        bk_wdat = '0;
        idx     = 0;
        for (int b = 0; b < BANKS_N; b++) begin
            for (int k = 0; k < CH_N; k++) begin
                idx = (int'(rr_q[b]) + k) % CH_N;
                if (!bk_hit[b] && req_vld_i[idx] && req_bank_i[idx*BANK_W +: BANK_W] == BANK_W'(b)) begin
                    bk_hit[b]  = 1'b1;
                    gnt[idx]   = 1'b1;
                    rr_d[b]    = PTR_W'((idx + 1) % CH_N);
                    bk_we[b]   = req_wr_i[idx];
                    bk_addr[b] = req_addr_i[idx*ADDR_W +: ADDR_W];
                    bk_wdat[b] = req_wdata_i[idx*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign req_rdy_o = gnt;
    assign rd_acc    = gnt & ~req_wr_i;
    assign cflt_d    = (|(req_vld_i & ~gnt) && cflt_q != 16'hFFFF) ? cflt_q + 16'd1 : cflt_q;

    // Data stages only load behind a valid, so the last stage holds its value between responses.
    always_comb begin
        p_vld_d = p_vld_q;
        p_tag_d = p_tag_q;
        p_dat_d = p_dat_q;
        for (int c = 0; c < CH_N; c++) begin
            p_vld_d[0][c] = rd_acc[c];
            if (rd_acc[c]) begin
                p_tag_d[0][c] = req_tag_i[c*TAG_W +: TAG_W];
                p_dat_d[0][c] = mem_q[req_bank_i[c*BANK_W +: BANK_W]][req_addr_i[c*ADDR_W +: ADDR_W]];
            end
            for (int s = 1; s < RD_LAT; s++) begin
                p_vld_d[s][c] = p_vld_q[s-1][c];
                if (p_vld_q[s-1][c]) begin
                    p_tag_d[s][c] = p_tag_q[s-1][c];
                    p_dat_d[s][c] = p_dat_q[s-1][c];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rr_q    <= '0;
            cflt_q  <= '0;
            p_vld_q <= '0;
            p_tag_q <= '0;
            p_dat_q <= '0;
        end else begin
            rr_q    <= rr_d;
            cflt_q  <= cflt_d;
            p_vld_q <= p_vld_d;
            p_tag_q <= p_tag_d;
            p_dat_q <= p_dat_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < BANKS_N; b++)
            if (bk_we[b]) mem_q[b][bk_addr[b]] <= bk_wdat[b];
    end

    assign rsp_vld_o  = p_vld_q[RD_LAT-1];
    assign rsp_tag_o  = p_tag_q[RD_LAT-1];
    assign rsp_dat_o  = p_dat_q[RD_LAT-1];
    assign cflt_cnt_o = cflt_q;

    always_comb begin
        bad_bank = '0;
        for (int c = 0; c < CH_N; c++)
            bad_bank[c] = req_vld_i[c] && (int'(req_bank_i[c*BANK_W +: BANK_W]) >= BANKS_N);
    end

    assert property (@(posedge clk_i) disable iff (arst_i) !(|bad_bank));
endmodule
